// File: rtl/seq_alu.sv
// Multi-cycle ALU: single-cycle base integer ops plus iterative unsigned MUL/DIVU/REMU,
// with valid/ready handshakes on both the operand and the result side.
module seq_alu #(
  parameter int N     = 32,
  parameter int CNT_W = $clog2(N) + 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [3:0]   opc,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] w,
  output logic         zero,
  output logic         neg,
  output logic         err
);

  typedef enum logic [1:0] {IDLE, ITER, DONE} state_t;

  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_SUB  = 4'b0001;
  localparam logic [3:0] OP_AND  = 4'b0010;
  localparam logic [3:0] OP_OR   = 4'b0011;
  localparam logic [3:0] OP_XOR  = 4'b0100;
  localparam logic [3:0] OP_SLT  = 4'b0101;
  localparam logic [3:0] OP_SLTU = 4'b0110;
  localparam logic [3:0] OP_MUL  = 4'b1000;
  localparam logic [3:0] OP_DIVU = 4'b1001;
  localparam logic [3:0] OP_REMU = 4'b1010;

  state_t           state, state_nx;
  logic [3:0]       op_q;
  logic [CNT_W-1:0] cnt;
  logic [2*N-1:0]   sh;    // MUL: shifting multiplicand; DIV: {remainder, dividend/quotient}
  logic [N-1:0]     opb;   // MUL: shifting multiplier; DIV: divisor
  logic [N-1:0]     acc;   // MUL: partial product

  logic [N-1:0] single_res;
  logic         single_bad;
  logic         is_iter;
  logic         last;
  logic [N-1:0] mul_nx;
  logic [N:0]   rem_sh;
  logic [N:0]   diff;
  logic         fits;
  logic [2*N-1:0] div_nx;

  always_comb begin
    single_res = '0;
    single_bad = 1'b0;
    is_iter    = 1'b0;
    unique case (opc)
      OP_ADD:  single_res = a + b;
      OP_SUB:  single_res = a - b;
      OP_AND:  single_res = a & b;
      OP_OR:   single_res = a | b;
      OP_XOR:  single_res = a ^ b;
      OP_SLT:  single_res[0] = $signed(a) < $signed(b);
      OP_SLTU: single_res[0] = a < b;
      OP_MUL, OP_DIVU, OP_REMU: is_iter = 1'b1;
      default: single_bad = 1'b1;
    endcase
  end

  always_comb begin
    last   = (cnt == CNT_W'(N - 1));
    mul_nx = opb[0] ? acc + sh[N-1:0] : acc;
    // Restoring step: bit N of the difference is the borrow, so it doubles as "does not fit".
    rem_sh = sh[2*N-1:N-1];
    diff   = rem_sh - {1'b0, opb};
    fits   = ~diff[N];
    div_nx = {(fits ? diff[N-1:0] : rem_sh[N-1:0]), sh[N-2:0], fits};
  end

  always_comb begin
    state_nx  = state;
    in_ready  = (state == IDLE);
    out_valid = (state == DONE);
    unique case (state)
      IDLE: if (in_valid) state_nx = is_iter ? ITER : DONE;
      ITER: if (last) state_nx = DONE;
      DONE: if (out_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      op_q <= '0;
      cnt  <= '0;
      sh   <= '0;
      opb  <= '0;
      acc  <= '0;
      w    <= '0;
      err  <= 1'b0;
    end else begin
      unique case (state)
        IDLE: if (in_valid) begin
          op_q <= opc;
          cnt  <= '0;
          acc  <= '0;
          sh   <= {{N{1'b0}}, a};
          opb  <= b;
          err  <= single_bad;
          if (!is_iter) w <= single_res;
        end
        ITER: begin
          cnt <= cnt + 1'b1;
          if (op_q == OP_MUL) begin
            acc <= mul_nx;
            sh  <= sh << 1;
            opb <= opb >> 1;
            if (last) w <= mul_nx;
          end else begin
            sh <= div_nx;
            if (last) w <= (op_q == OP_DIVU) ? div_nx[N-1:0] : div_nx[2*N-1:N];
          end
        end
        default: ;
      endcase
    end
  end

  assign zero = (w == '0);
  assign neg  = w[N-1];

endmodule
